// File: rtl/filter_pkg.sv
// rtl/filter_pkg.sv - shared types and defaults for the filter datapath
package filter_pkg;

  // Rounding applied when dropping the fractional bits of an accumulator sample
  typedef enum logic [1:0] {
    RND_TRUNC      = 2'd0,
    RND_HALF_UP    = 2'd1,
    RND_CONVERGENT = 2'd2,
    RND_HALF_AWAY  = 2'd3
  } round_mode_e;

  // Defaults shared with the accumulator block
  localparam int DEF_IN_W       = 40;
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_SHIFT_BASE = 12;

  // Channel tag width: at least one bit even for a single channel
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/filter_round_sat_if.sv
// rtl/filter_round_sat_if.sv - sample in/out handshake bundle for the output stage
interface filter_round_sat_if
  import filter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int CH_W  = 1
);

  // Upstream side: accumulator samples
  logic                     in_valid;
  logic                     in_ready;
  logic [CH_W-1:0]          in_ch;
  logic signed [IN_W-1:0]   acc_in;

  // Downstream side: rounded, clipped results
  logic                     out_valid;
  logic                     out_ready;
  logic [CH_W-1:0]          out_ch;
  logic signed [OUT_W-1:0]  filter_out;

  // Producer of samples and consumer of results
  modport master (
    output in_valid, in_ch, acc_in, out_ready,
    input  in_ready, out_valid, out_ch, filter_out
  );

  // The output stage itself
  modport slave (
    input  in_valid, in_ch, acc_in, out_ready,
    output in_ready, out_valid, out_ch, filter_out
  );

endinterface

// File: rtl/filter_clip.sv
// rtl/filter_clip.sv - arithmetic shift, overflow detect and saturate/wrap
module filter_clip
  import filter_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int S_W   = $clog2(DEF_IN_W + 1)
) (
  input  logic [IN_W:0]     i_sum,
  input  logic [S_W-1:0]    i_shift,
  input  logic              i_sat,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_ovf
);

  logic signed [IN_W:0]      w_q;
  logic [IN_W-OUT_W+1:0]     w_hi;

  // The bias has already been added, so a floor shift completes the rounding
  assign w_q  = $signed(i_sum) >>> i_shift;

  // q fits OUT_W bits only when every bit from the output sign upwards agrees
  assign w_hi  = w_q[IN_W:OUT_W-1];
  assign o_ovf = !((&w_hi) || !(|w_hi));

  // Clamp to the rail matching the sign of q, otherwise keep the low bits (wrap)
  always_comb begin
    o_data = w_q[OUT_W-1:0];
    if (o_ovf && i_sat) begin
      o_data = w_q[IN_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/filter_round_sat.sv
// rtl/filter_round_sat.sv - two-stage round/shift/clip output stage with overflow flags
module filter_round_sat
  import filter_pkg::*;
#(
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int NUM_CH     = 2,
  parameter int SHIFT_BASE = DEF_SHIFT_BASE,
  parameter int SHIFT_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  filter_round_sat_if.slave    bus,
  input  logic [SHIFT_W-1:0]   rf_shift,
  input  logic [1:0]           rf_round_mode,
  input  logic                 rf_sat,
  input  logic                 trig_ovf_clear,
  output logic [NUM_CH-1:0]    ro_ovf_flag
);

  localparam int CH_W = ch_width(NUM_CH);
  // Wide enough to hold any total shift, which is always below IN_W
  localparam int S_W  = $clog2(IN_W + 1);

  // Stage 1 holds the biased sum plus the config captured with the sample
  logic                 r_s1_valid;
  logic [IN_W:0]        r_s1_sum;
  logic [S_W-1:0]       r_s1_shift;
  logic                 r_s1_sat;
  logic [CH_W-1:0]      r_s1_ch;

  // Stage 2 is the output register
  logic                 r_out_valid;
  logic [OUT_W-1:0]     r_filter_out;
  logic [CH_W-1:0]      r_out_ch;
  logic [NUM_CH-1:0]    r_ovf_flag;

  logic                 w_in_ready;
  logic                 w_s2_ready;
  logic                 w_in_fire;
  logic                 w_s2_load;
  logic [S_W-1:0]       w_s;
  logic [IN_W:0]        w_half;
  logic [IN_W:0]        w_bias;
  logic [IN_W:0]        w_sum;
  logic [OUT_W-1:0]     w_clip_data;
  logic                 w_clip_ovf;
  logic [NUM_CH-1:0]    w_ovf_set;

  // No skid buffer: readiness ripples back combinationally from out_ready
  assign w_s2_ready = !r_out_valid || bus.out_ready;
  assign w_in_ready = !r_s1_valid || w_s2_ready;
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_s2_load  = r_s1_valid && w_s2_ready;

  assign w_s = S_W'(SHIFT_BASE) + S_W'(rf_shift);

  // Rounding bias: each mode is floor((acc + bias) / 2^s) with a different bias
  always_comb begin
    w_half = (IN_W + 1)'(1) << (w_s - S_W'(1));
    w_bias = '0;
    case (round_mode_e'(rf_round_mode))
      RND_TRUNC:      w_bias = '0;
      RND_HALF_UP:    w_bias = w_half;
      // Ties go up only when the kept LSB is odd, so results land on even values
      RND_CONVERGENT: w_bias = w_half - (IN_W + 1)'(1) + (IN_W + 1)'(bus.acc_in[w_s]);
      // Negative ties must not round up, so take one off the bias for negatives
      RND_HALF_AWAY:  w_bias = w_half - (IN_W + 1)'(bus.acc_in[IN_W-1]);
      default:        w_bias = '0;
    endcase
  end

  // One guard bit above the sign keeps the biased add from overflowing
  assign w_sum = {bus.acc_in[IN_W-1], bus.acc_in} + w_bias;

  // Stage 1 register: advances whenever it is empty or stage 2 takes its content
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_shift <= '0;
      r_s1_sat   <= 1'b0;
      r_s1_ch    <= '0;
    end else if (w_in_ready) begin
      r_s1_valid <= bus.in_valid;
      if (w_in_fire) begin
        r_s1_sum   <= w_sum;
        r_s1_shift <= w_s;
        r_s1_sat   <= rf_sat;
        r_s1_ch    <= bus.in_ch;
      end
    end
  end

  filter_clip #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .S_W   (S_W)
  ) u_clip (
    .i_sum   (r_s1_sum),
    .i_shift (r_s1_shift),
    .i_sat   (r_s1_sat),
    .o_data  (w_clip_data),
    .o_ovf   (w_clip_ovf)
  );

  // Stage 2 register: holds its sample steady while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_filter_out <= '0;
      r_out_ch     <= '0;
    end else if (w_s2_ready) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_filter_out <= w_clip_data;
        r_out_ch     <= r_s1_ch;
      end
    end
  end

  // Flag set pulses; tags beyond NUM_CH match no channel and set nothing
  always_comb begin
    w_ovf_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_s2_load && w_clip_ovf && (r_s1_ch == CH_W'(i))) begin
        w_ovf_set[i] = 1'b1;
      end
    end
  end

  // Sticky flags: a clear and a new overflow in the same cycle leaves that flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_flag <= '0;
    end else begin
      r_ovf_flag <= (trig_ovf_clear ? '0 : r_ovf_flag) | w_ovf_set;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_ch     = r_out_ch;
  assign bus.filter_out = r_filter_out;
  assign ro_ovf_flag    = r_ovf_flag;

endmodule

// File: tb/tb_filter_round_sat.sv
// tb/tb_filter_round_sat.sv - self-checking bench for filter_round_sat
module tb_filter_round_sat;
  import filter_pkg::*;

  localparam int IN_W   = 40;
  localparam int OUT_W  = 16;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int SBASE  = 12;

  typedef struct {
    logic signed [IN_W-1:0]  acc;
    logic [CH_W-1:0]         ch;
    logic [1:0]              mode;
    logic                    sat;
    logic signed [OUT_W-1:0] exp;
    logic [NUM_CH-1:0]       flag;
  } vec_t;

  typedef struct {
    logic signed [OUT_W-1:0] data;
    logic [CH_W-1:0]         ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] rf_shift = '0;
  logic [1:0] rf_round_mode = '0;
  logic       rf_sat = 1'b0;
  logic       trig_ovf_clear = 1'b0;
  logic [NUM_CH-1:0] ro_ovf_flag;

  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb[$];
  vec_t tbl[22];

  filter_round_sat_if #(.IN_W(IN_W), .OUT_W(OUT_W), .CH_W(CH_W)) bus ();

  filter_round_sat #(
    .IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .SHIFT_BASE(SBASE), .SHIFT_W(3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .rf_shift       (rf_shift),
    .rf_round_mode  (rf_round_mode),
    .rf_sat         (rf_sat),
    .trig_ovf_clear (trig_ovf_clear),
    .ro_ovf_flag    (ro_ovf_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: exact integer rounding on the remainder, then clip
  function automatic logic signed [OUT_W-1:0] model(input logic signed [IN_W-1:0] acc,
      input int s, input logic [1:0] md, input logic sat);
    longint a, d, fl, rem, h, q;
    a = acc;
    d = longint'(1) << s;
    fl = a >>> s;
    rem = a - fl * d;
    h = d / 2;
    q = fl;
    case (md)
      2'd1: if (rem >= h) q = fl + 1;
      2'd2: if (rem > h || (rem == h && fl[0])) q = fl + 1;
      2'd3: if (rem > h || (rem == h && a >= 0)) q = fl + 1;
      default: q = fl;
    endcase
    if (q > 32767 && sat) return 16'sh7fff;
    if (q < -32768 && sat) return 16'sh8000;
    return 16'(q);
  endfunction

  // Scoreboard consumer: every accepted output must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_out: got data %0h ch %0d, expected no output",
                 bus.filter_out, bus.out_ch);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 64'(bus.filter_out), 64'(e.data));
        check("out_ch", 64'(bus.out_ch), 64'(e.ch));
      end
    end
  end

  // Called at posedge+1; presents a sample and returns at posedge+1 after its transfer
  task automatic send(input logic signed [IN_W-1:0] acc, input logic [CH_W-1:0] ch,
      input logic [2:0] sh, input logic [1:0] md, input logic sat,
      input logic signed [OUT_W-1:0] exp);
    int t;
    exp_t e;
    t = 0;
    bus.acc_in = acc;
    bus.in_ch = ch;
    bus.in_valid = 1'b1;
    rf_shift = sh;
    rf_round_mode = md;
    rf_sat = sat;
    @(negedge clk);
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0, expected 1 within 100 cycles");
    end else begin
      e.data = exp;
      e.ch = ch;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_m(input logic signed [IN_W-1:0] acc, input logic [CH_W-1:0] ch,
      input logic [2:0] sh, input logic [1:0] md, input logic sat);
    send(acc, ch, sh, md, sat, model(acc, SBASE + int'(sh), md, sat));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    trig_ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    trig_ovf_clear = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [IN_W-1:0] r;
    bus.in_valid = 1'b0;
    bus.in_ch = '0;
    bus.acc_in = '0;
    bus.out_ready = 1'b1;

    tbl[0]  = '{40'sd6144,  1'b0, 2'd0, 1'b0, 16'sd1, 2'b00};
    tbl[1]  = '{40'sd6144,  1'b0, 2'd1, 1'b0, 16'sd2, 2'b00};
    tbl[2]  = '{40'sd6144,  1'b0, 2'd2, 1'b0, 16'sd2, 2'b00};
    tbl[3]  = '{40'sd6144,  1'b0, 2'd3, 1'b0, 16'sd2, 2'b00};
    tbl[4]  = '{40'sd10240, 1'b0, 2'd0, 1'b0, 16'sd2, 2'b00};
    tbl[5]  = '{40'sd10240, 1'b0, 2'd1, 1'b0, 16'sd3, 2'b00};
    tbl[6]  = '{40'sd10240, 1'b0, 2'd2, 1'b0, 16'sd2, 2'b00};
    tbl[7]  = '{40'sd10240, 1'b0, 2'd3, 1'b0, 16'sd3, 2'b00};
    tbl[8]  = '{-40'sd10240, 1'b1, 2'd0, 1'b1, -16'sd3, 2'b00};
    tbl[9]  = '{-40'sd10240, 1'b1, 2'd1, 1'b1, -16'sd2, 2'b00};
    tbl[10] = '{-40'sd10240, 1'b1, 2'd2, 1'b1, -16'sd2, 2'b00};
    tbl[11] = '{-40'sd10240, 1'b1, 2'd3, 1'b1, -16'sd3, 2'b00};
    tbl[12] = '{-40'sd6144, 1'b0, 2'd0, 1'b1, -16'sd2, 2'b00};
    tbl[13] = '{-40'sd6144, 1'b0, 2'd1, 1'b1, -16'sd1, 2'b00};
    tbl[14] = '{-40'sd6144, 1'b0, 2'd2, 1'b1, -16'sd2, 2'b00};
    tbl[15] = '{-40'sd6144, 1'b0, 2'd3, 1'b1, -16'sd2, 2'b00};
    tbl[16] = '{40'sd134217728, 1'b1, 2'd0, 1'b1, 16'sh7fff, 2'b10};
    tbl[17] = '{40'sd134217728, 1'b1, 2'd0, 1'b0, 16'sh8000, 2'b10};
    tbl[18] = '{-40'sd134221824, 1'b1, 2'd0, 1'b1, 16'sh8000, 2'b10};
    tbl[19] = '{40'sd134215679, 1'b0, 2'd1, 1'b1, 16'sh7fff, 2'b00};
    tbl[20] = '{40'sd134215680, 1'b0, 2'd1, 1'b1, 16'sh7fff, 2'b01};
    tbl[21] = '{-40'sd134217728, 1'b1, 2'd0, 1'b1, 16'sh8000, 2'b00};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_filter_out", 64'(bus.filter_out), 64'd0);
    check("rst_out_ch", 64'(bus.out_ch), 64'd0);
    check("rst_ovf_flag", 64'(ro_ovf_flag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      pulse_clear();
      send(tbl[i].acc, tbl[i].ch, 3'd0, tbl[i].mode, tbl[i].sat, tbl[i].exp);
      idle();
      drain();
      check($sformatf("tbl_flag_%0d", i), 64'(ro_ovf_flag), 64'(tbl[i].flag));
    end

    pulse_clear();
    send_m(40'sd134217728, 1'b1, 3'd0, 2'd0, 1'b1);
    idle();
    drain();
    check("flag_set_ch1", 64'(ro_ovf_flag), 64'd2);
    pulse_clear();
    check("flag_clear_alone", 64'(ro_ovf_flag), 64'd0);

    send_m(40'sd134217728, 1'b1, 3'd0, 2'd0, 1'b1);
    idle();
    drain();
    send_m(-40'sd134221824, 1'b0, 3'd0, 2'd0, 1'b1);
    idle();
    trig_ovf_clear = 1'b1;
    @(posedge clk);
    #1;
    trig_ovf_clear = 1'b0;
    check("flag_clear_vs_set", 64'(ro_ovf_flag), 64'd1);
    drain();

    bus.out_ready = 1'b0;
    send_m(40'sd6144, 1'b0, 3'd0, 2'd1, 1'b1);
    send_m(40'sd2883584, 1'b1, 3'd7, 2'd1, 1'b1);
    idle();
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_data", 64'(bus.filter_out), 64'd2);
      check("bp_hold_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send_m(-40'sd1572864, 1'b0, 3'd7, 2'd0, 1'b1);
    idle();
    drain();

    for (int k = 0; k < 40; k++) begin
      r = 40'({$urandom(), $urandom()});
      r = r >>> $urandom_range(0, 26);
      send_m(r, CH_W'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    idle();
    drain();
    pulse_clear();

    bus.out_ready = 1'b0;
    send_m(40'sd134217728, 1'b1, 3'd0, 2'd0, 1'b1);
    send_m(40'sd4096, 1'b0, 3'd0, 2'd0, 1'b1);
    idle();
    @(negedge clk);
    check("pre_rst_flag", 64'(ro_ovf_flag), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_flag", 64'(ro_ovf_flag), 64'd0);
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_valid", 64'(bus.out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_round_sat.md
# filter_round_sat

Parametrised, multi-channel output stage for the filter datapath. Converts a wide signed accumulator sample into an `OUT_W`-bit result. Applies a programmable right shift, one of four rounding modes, and saturate-or-wrap clipping, with a sticky overflow flag per channel. Sits between the filter MAC/accumulator and the output formatter, coupled to both by a 2-stage valid/ready pipeline.

## Interface
Parameters:
- `IN_W`, 40, accumulator width (signed).
- `OUT_W`, 16, output width (signed).
- `NUM_CH`, 2, channel count; `CH_W = max(1, clog2(NUM_CH))`.
- `SHIFT_BASE`, 12, fixed shift offset, ≥ 1.
- `SHIFT_W`, 3, width of programmable shift; `SHIFT_BASE + 2^SHIFT_W - 1 < IN_W`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  stage 1 can accept.
- `in_ch`  in  CH_W  channel tag of input sample.
- `acc_in`  in  IN_W  signed accumulator sample.
- `rf_shift`  in  SHIFT_W  extra shift; total shift `s = SHIFT_BASE + rf_shift`.
- `rf_round_mode`  in  2  rounding mode: 0 truncate (floor), 1 half-up, 2 convergent (half-even), 3 half-away-from-zero.
- `rf_sat`  in  1  1 saturate on overflow, 0 wrap.
- `trig_ovf_clear`  in  1  one-cycle pulse, clears all overflow flags.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts.
- `out_ch`  out  CH_W  channel tag travelling with the sample.
- `filter_out`  out  OUT_W  rounded and clipped result.
- `ro_ovf_flag`  out  NUM_CH  sticky per-channel overflow flags.

## Operation
- Input transfer occurs when `in_valid && in_ready`. At transfer, `rf_shift`, `rf_round_mode` and `rf_sat` are captured with the sample. Config changes affect only samples accepted afterwards.
- Stage 1: sign-extend `acc_in` to `IN_W+1` bits and add a bias. The bias depends on the mode:
  - mode 0: 0.
  - mode 1: `2^(s-1)`.
  - mode 2: `2^(s-1) - 1 + acc_in[s]`.
  - mode 3: `2^(s-1) - acc_in[IN_W-1]`.
- Stage 1 register holds the sum, `s`, `rf_sat` and `in_ch`. The extra bit means the add never overflows.
- Stage 2: `q = sum >>> s` (arithmetic).
  - If `q > 2^(OUT_W-1)-1` or `q < -2^(OUT_W-1)`, the sample has overflowed.
  - On overflow with `rf_sat=1`, the output is the max or min value, matching the sign of `q`.
  - On overflow with `rf_sat=0`, the output is `q[OUT_W-1:0]`.
  - Without overflow, the output is `q[OUT_W-1:0]`.
- Overflow flag: `ro_ovf_flag[ch]` is set in the cycle the overflowing sample loads into the stage 2 register. It stays set until `trig_ovf_clear`.
- Clear together with a new overflow on channel `ch`: that flag ends at 1 (set wins), and all other flags clear.
- A `ch ≥ NUM_CH` tag is passed through unchanged and sets no flag.

## Timing
- Latency: 2 cycles from input transfer to `out_valid` when there is no backpressure.
- Throughput: 1 sample/cycle.
- Stage readiness:
  - `in_ready = !s1_valid || s2_ready`.
  - `s2_ready = !out_valid || out_ready`.
  - `in_ready` is combinational from `out_ready`; there is no skid buffer.
- While `out_valid && !out_ready`, `filter_out`, `out_ch` and `out_valid` hold stable.
- Maximum occupancy is 2 samples in flight. With `out_ready` held low, `in_ready` drops after 2 accepted samples.
- Reset values: `out_valid=0`, `filter_out=0`, `out_ch=0`, `ro_ovf_flag=0`, `in_ready=1` (stage 1 empty).
- Reset asserted mid-operation discards all in-flight samples, with no partial output. The first transfer is possible on the first clock edge after `rst` deasserts.

## Structure
- Shared package `filter_pkg` holds:
  - round-mode enum: `RND_TRUNC`, `RND_HALF_UP`, `RND_CONVERGENT`, `RND_HALF_AWAY`.
  - default `IN_W`, `OUT_W` and `SHIFT_BASE` constants, shared with the accumulator block.
- One sub-module, `filter_clip`, is natural: combinational shift, overflow detect and saturate/wrap for stage 2. It is reusable by other output stages.
- Stage registers and the flag logic stay in the top level.

## Test plan
All scenarios use the defaults with `rf_shift=0` (s=12, one LSB of output = 4096).
- Rounding at half, positive: `acc_in=6144` (1.5) in modes 0/1/2/3 -> `filter_out` = 1/2/2/2. `acc_in=10240` (2.5) -> 2/3/2/3.
- Rounding at half, negative: `acc_in=-10240` (−2.5) in modes 0/1/2/3 -> −3/−2/−2/−3. `acc_in=-6144` (−1.5) -> −2/−1/−2/−2.
- Overflow, ch1: `acc_in=32768·4096` with `rf_sat=1` -> `0x7FFF` and `ro_ovf_flag=2'b10`. Same input with `rf_sat=0` -> `0x8000`. `acc_in=-32769·4096` with `rf_sat=1` -> `0x8000`.
- Flag clear: pulse `trig_ovf_clear` alone -> flags 0. Pulse it in the same cycle as an overflowing ch0 sample loads into stage 2 -> `ro_ovf_flag=2'b01`.
- Backpressure: hold `out_ready=0` and stream samples A, B, C -> `in_ready` drops after B and the output holds A. Raise `out_ready` -> A, B, C emerge in order with no loss or duplication. Change `rf_shift` to 7 after A is accepted -> A still uses s=12.
- Reset: assert `rst` with 2 samples in flight -> `out_valid=0` and flags 0 at once. No stale samples appear after release.
